// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - register map, STAT bit positions and FSM states for lcd_num_loader
package lcd_pkg;

  localparam logic [7:0] CTRL_OFS   = 8'h00;
  localparam logic [7:0] STAT_OFS   = 8'h04;
  localparam logic [7:0] VALUE_BASE = 8'h10;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_BLANK   = 1;
  localparam int STAT_BUSY    = 16;
  localparam int STAT_IRQ     = 17;
  localparam int STAT_OVF_LSB = 24;
  localparam int STAT_OVF_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PICK  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one bit per cycle, with guard digit overflow detect
module bin2bcd_seq
  import lcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BCD_W = DIGITS * 4 + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             sticky_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d <= DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end
    end
  end

  // A bit leaving the guard digit means the value is far beyond range; keep it sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bin_q    <= bin_in;
        bcd_q    <= '0;
        cnt_q    <= CNT_W'(BIN_W);
        busy_q   <= 1'b1;
        sticky_q <= 1'b0;
      end else if (busy_q) begin
        bcd_q    <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_q    <= {bin_q[BIN_W-2:0], 1'b0};
        sticky_q <= sticky_q | bcd_adj[BCD_W-1];
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q[DIGITS*4-1:0];
  assign ovf     = sticky_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);

endmodule

// File: rtl/lcd_num_loader.sv
// rtl/lcd_num_loader.sv - register-mapped multi-channel binary to BCD loader feeding lcd_array
module lcd_num_loader
  import lcd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  addr_32b_i,
  input  logic                         wren_i,
  input  logic                         rden_i,
  input  logic [31:0]                  din_32b_i,
  output logic [31:0]                  dout_32b_o,
  output logic                         dout_32b_valid_o,
  output logic                         interrupt_o,
  output logic [NUM_CH*DIGITS*4-1:0]   digits_o,
  output logic [NUM_CH-1:0]            digits_valid_o
);

  localparam int FIELD_W = DIGITS * 4;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OVF_W   = (NUM_CH < STAT_OVF_W) ? NUM_CH : STAT_OVF_W;
  localparam logic [5:0] CTRL_WORD = CTRL_OFS[7:2];
  localparam logic [5:0] STAT_WORD = STAT_OFS[7:2];
  localparam logic [5:0] VAL_WORD  = VALUE_BASE[7:2];

  logic [5:0]                 word;
  logic                       val_hit;
  logic [CH_W-1:0]            val_ch;
  logic                       wr_ctrl;
  logic                       wr_stat;
  logic [31:0]                rdata;
  logic [BIN_W-1:0]           value_q [NUM_CH];
  logic [NUM_CH-1:0]          pending_q;
  logic [NUM_CH-1:0]          pend_set;
  logic [NUM_CH-1:0]          pend_clr;
  logic                       irq_en_q;
  logic                       irq_en_d;
  logic                       blank_q;
  logic                       irq_flag_q;
  logic                       irq_flag_d;
  logic [OVF_W-1:0]           ovf_q;
  logic [OVF_W-1:0]           ovf_set;
  logic [OVF_W-1:0]           ovf_clr;
  logic [NUM_CH*FIELD_W-1:0]  field_q;
  state_t                     state_q;
  state_t                     state_d;
  logic [CH_W-1:0]            last_q;
  logic [CH_W-1:0]            pick_idx;
  logic                       pick_found;
  logic                       start;
  logic                       finish;
  logic                       bcd_busy;
  logic                       bcd_done;
  logic                       bcd_ovf;
  logic [FIELD_W-1:0]         bcd_out;
  logic                       unused;

  assign word   = addr_32b_i[7:2];
  assign unused = ^{addr_32b_i, din_32b_i};

  always_comb begin
    val_hit = 1'b0;
    val_ch  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (word == 6'(int'(VAL_WORD) + c)) begin
        val_hit = 1'b1;
        val_ch  = CH_W'(c);
      end
    end
  end

  assign wr_ctrl = wren_i && (word == CTRL_WORD);
  assign wr_stat = wren_i && (word == STAT_WORD);

  // Read mux sees register state before any same-cycle write lands.
  always_comb begin
    rdata = '0;
    if (word == CTRL_WORD) begin
      rdata[CTRL_IRQ_EN] = irq_en_q;
      rdata[CTRL_BLANK]  = blank_q;
    end else if (word == STAT_WORD) begin
      rdata[NUM_CH-1:0]               = pending_q;
      rdata[STAT_BUSY]                = (state_q != ST_IDLE) || bcd_busy;
      rdata[STAT_IRQ]                 = irq_flag_q;
      rdata[STAT_OVF_LSB +: OVF_W]    = ovf_q;
    end else if (val_hit) begin
      rdata[BIN_W-1:0] = value_q[val_ch];
    end
  end

  // Round-robin: search starts at the channel after the one served last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!pick_found && pending_q[CH_W'((int'(last_q) + i) % NUM_CH)]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'((int'(last_q) + i) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|pending_q) state_d = ST_PICK;
      ST_PICK:  state_d = ST_SHIFT;
      ST_SHIFT: if (bcd_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start    = (state_q == ST_PICK);
    finish   = (state_q == ST_SHIFT) && bcd_done;
    pend_clr = start ? (NUM_CH'(1) << pick_idx) : '0;
    pend_set = (wren_i && val_hit) ? (NUM_CH'(1) << val_ch) : '0;
  end

  always_comb begin
    ovf_set = '0;
    for (int c = 0; c < OVF_W; c++) begin
      ovf_set[c] = finish && bcd_ovf && (last_q == CH_W'(c));
    end
    ovf_clr    = wr_stat ? din_32b_i[STAT_OVF_LSB +: OVF_W] : '0;
    irq_flag_d = (irq_flag_q & ~(wr_stat & din_32b_i[STAT_IRQ])) | finish;
    irq_en_d   = wr_ctrl ? din_32b_i[CTRL_IRQ_EN] : irq_en_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) value_q[c] <= '0;
      pending_q        <= '0;
      irq_en_q         <= 1'b0;
      blank_q          <= 1'b0;
      irq_flag_q       <= 1'b0;
      ovf_q            <= '0;
      field_q          <= '0;
      last_q           <= CH_W'(NUM_CH - 1);
      digits_valid_o   <= '0;
      interrupt_o      <= 1'b0;
      dout_32b_valid_o <= 1'b0;
      dout_32b_o       <= '0;
    end else begin
      if (wren_i && val_hit) value_q[val_ch] <= din_32b_i[BIN_W-1:0];
      pending_q <= (pending_q & ~pend_clr) | pend_set;
      if (wr_ctrl) begin
        irq_en_q <= din_32b_i[CTRL_IRQ_EN];
        blank_q  <= din_32b_i[CTRL_BLANK];
      end
      irq_flag_q <= irq_flag_d;
      ovf_q      <= (ovf_q & ~ovf_clr) | ovf_set;
      if (start) last_q <= pick_idx;
      if (finish) begin
        field_q[int'(last_q)*FIELD_W +: FIELD_W] <= bcd_ovf ? {DIGITS{4'h9}} : bcd_out;
      end
      digits_valid_o   <= finish ? (NUM_CH'(1) << last_q) : '0;
      interrupt_o      <= irq_flag_d & irq_en_d;
      dout_32b_valid_o <= wren_i | rden_i;
      dout_32b_o       <= rden_i ? rdata : '0;
    end
  end

  assign digits_o = blank_q ? {(NUM_CH*DIGITS){4'hF}} : field_q;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (value_q[pick_idx]),
    .busy    (bcd_busy),
    .done    (bcd_done),
    .bcd_out (bcd_out),
    .ovf     (bcd_ovf)
  );

endmodule
